apb_master_arbiter: RTL and testbench

Round-robin APB master that shares one APB slave port between `NREQ` local requesters. It accepts one request at a time, runs the APB SETUP/ACCESS sequence, waits on `PREADY`, and returns read data or a timeout error to the granted requester. It sits between internal masters (DMA, CPU shim, test sequencers) and the APB slave memory block.

---
 rtl/apb_master_arbiter_if.sv | 37 +++
 rtl/apb_master_arbiter.sv | 143 ++++++++++++++
 tb/tb_apb_master_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_arbiter_if.sv
// Bundles the requester-side and APB-side signals of apb_master_arbiter.
// No logic of its own; latency and flow control come from the arbiter.
// master modport is the arbiter's view, slave modport is the environment's view.
interface apb_master_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_write;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   rsp_err;
  logic                   busy;
  logic                   PSEL;
  logic                   PENABLE;
  logic                   PWRITE;
  logic [ADDR_W-1:0]      PADDR;
  logic [DATA_W-1:0]      PWDATA;
  logic [DATA_W-1:0]      PRDATA;
  logic                   PREADY;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB slave between NREQ requesters, one transfer in flight.
// Grant to response is 3 cycles minimum, +1 per PREADY wait, abort after TIMEOUT ACCESS cycles.
// Requesters wait on req_ready (held off while a transfer runs); the APB side stalls on PREADY.
module apb_master_arbiter #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic PCLK,
  input  logic PRESETn,
  apb_master_arbiter_if.master bus
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  owner;
  logic [CNT_W-1:0]  wait_cnt;

  logic              win_found;
  logic [PTR_W-1:0]  win_idx;
  logic [PTR_W:0]    cand;
  logic [PTR_W:0]    ptr_inc;
  logic [PTR_W-1:0]  ptr_nxt;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              timeout_hit;
  logic              done;
  logic              accept;
  logic              grant;

  // A transfer ends either on PREADY or on the last allowed wait cycle; PREADY wins a tie.
  assign timeout_hit = (state == ACCESS) && !bus.PREADY && (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign done        = (state == ACCESS) && (bus.PREADY || timeout_hit);
  assign accept      = (state == IDLE) || done;
  assign grant       = accept && win_found;

  assign bus.req_ready = (PRESETn && grant) ? (NREQ'(1) << win_idx) : '0;

  // Round-robin search starting at ptr, wrapping modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NREQ)) cand = cand - (PTR_W+1)'(NREQ);
      if (!win_found && bus.req_valid[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Pointer moves to the requester just after the winner.
  always_comb begin
    ptr_inc = {1'b0, win_idx} + (PTR_W+1)'(1);
    ptr_nxt = (ptr_inc == (PTR_W+1)'(NREQ)) ? '0 : ptr_inc[PTR_W-1:0];
  end

  // Select the winner's command fields from the packed request buses.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win_idx == PTR_W'(k)) begin
        sel_write = bus.req_write[k];
        sel_addr  = bus.req_addr[k*ADDR_W +: ADDR_W];
        sel_wdata = bus.req_wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state logic: a completion with a pending request goes straight back to SETUP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = grant ? SETUP : IDLE;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done) state_nxt = grant ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer, command capture, wait counter and response registers.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state         <= IDLE;
      ptr           <= '0;
      owner         <= '0;
      wait_cnt      <= '0;
      bus.PSEL      <= 1'b0;
      bus.PENABLE   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.PWRITE    <= 1'b0;
      bus.PADDR     <= '0;
      bus.PWDATA    <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      bus.PSEL    <= (state_nxt != IDLE);
      bus.PENABLE <= (state_nxt == ACCESS);
      bus.busy    <= (state_nxt != IDLE);

      if (grant) begin
        ptr        <= ptr_nxt;
        owner      <= win_idx;
        bus.PWRITE <= sel_write;
        bus.PADDR  <= sel_addr;
        bus.PWDATA <= sel_wdata;
      end

      if (state == SETUP)
        wait_cnt <= '0;
      else if (state == ACCESS && !bus.PREADY)
        wait_cnt <= wait_cnt + CNT_W'(1);

      if (done) begin
        bus.rsp_valid <= NREQ'(1) << owner;
        bus.rsp_err   <= timeout_hit;
        bus.rsp_rdata <= (bus.PREADY && !bus.PWRITE) ? bus.PRDATA : '0;
      end else begin
        bus.rsp_valid <= '0;
        bus.rsp_err   <= 1'b0;
        bus.rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a cycle-timing reference model.
// The model tracks each transfer by its age since grant and follows the timing rules.
// Literal checks at key cycles pin the model to hand-computed values.
module tb_apb_master_arbiter;
  localparam int NREQ    = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic pclk = 1'b0;
  logic presetn;

  apb_master_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_master_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(pclk),
    .PRESETn(presetn),
    .bus(bus)
  );

  always #5 pclk = ~pclk;

  int errors = 0;
  int checks = 0;
  int grant_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: a transfer is described by its age in cycles since grant (1 = SETUP).
  bit                m_ok = 0;
  bit                m_active = 0;
  int                m_age = 0;
  int                m_ptr = 0;
  int                m_owner = 0;
  logic              m_pwrite = 0;
  logic [ADDR_W-1:0] m_paddr = '0;
  logic [DATA_W-1:0] m_pwdata = '0;
  logic [NREQ-1:0]   m_rsp_vec = '0;
  logic [DATA_W-1:0] m_rsp_rdata = '0;
  logic              m_rsp_err = 0;

  // Compare process: check DUT against the model mid-cycle, then advance the model
  // using the inputs that the DUT will sample at the coming rising edge.
  initial begin : model
    int win;
    int idx;
    bit fin;
    bit tmo;
    bit accept;
    logic [NREQ-1:0] exp_rdy;
    forever begin
      @(negedge pclk);
      fin = 0; tmo = 0; win = -1; accept = 0;
      if (presetn === 1'b1) begin
        fin    = m_active && m_age >= 2 && (bus.PREADY || (m_age - 1) >= TIMEOUT);
        tmo    = fin && !bus.PREADY;
        accept = !m_active || fin;
        if (accept)
          for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (win < 0 && ((bus.req_valid >> idx) & 1) != 0) win = idx;
          end
      end
      exp_rdy = (win >= 0) ? (NREQ'(1) << win) : '0;
      for (int i = 0; i < NREQ; i++)
        if (((bus.req_ready >> i) & 1) != 0) grant_log.push_back(i);

      if (m_ok) begin
        check("req_ready", bus.req_ready, exp_rdy);
        check("psel",      bus.PSEL,      m_active);
        check("penable",   bus.PENABLE,   m_active && m_age >= 2);
        check("busy",      bus.busy,      m_active);
        check("paddr",     bus.PADDR,     m_paddr);
        check("pwdata",    bus.PWDATA,    m_pwdata);
        check("pwrite",    bus.PWRITE,    m_pwrite);
        check("rsp_valid", bus.rsp_valid, m_rsp_vec);
        check("rsp_err",   bus.rsp_err,   m_rsp_err);
        check("rsp_rdata", bus.rsp_rdata, m_rsp_rdata);
      end

      if (presetn !== 1'b1) begin
        m_ok = 1; m_active = 0; m_age = 0; m_ptr = 0; m_owner = 0;
        m_pwrite = 0; m_paddr = '0; m_pwdata = '0;
        m_rsp_vec = '0; m_rsp_rdata = '0; m_rsp_err = 0;
      end else begin
        m_rsp_vec = '0; m_rsp_rdata = '0; m_rsp_err = 0;
        if (fin) begin
          m_rsp_vec   = NREQ'(1) << m_owner;
          m_rsp_err   = tmo;
          m_rsp_rdata = (!tmo && !m_pwrite) ? bus.PRDATA : '0;
        end
        if (win >= 0) begin
          m_active = 1;
          m_age    = 1;
          m_owner  = win;
          m_ptr    = (win + 1) % NREQ;
          m_pwrite = bus.req_write[win];
          m_paddr  = ADDR_W'(bus.req_addr >> (win * ADDR_W));
          m_pwdata = DATA_W'(bus.req_wdata >> (win * DATA_W));
        end else if (fin) begin
          m_active = 0;
        end else if (m_active) begin
          m_age++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    presetn       = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.PREADY    = 1'b0;
    bus.PRDATA    = '0;

    // Reset with requests pending: no grant may leak out.
    tick(); tick(); tick();
    check("rst_req_ready", bus.req_ready, 2'b00);
    check("rst_psel",      bus.PSEL, 1'b0);
    check("rst_busy",      bus.busy, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 2'b00);
    check("rst_paddr",     bus.PADDR, 32'h0);
    bus.req_valid = '0;
    presetn = 1'b1;
    tick();

    // Single write from req0 with zero wait states.
    bus.req_valid = 2'b01; bus.req_write = 2'b01;
    bus.req_addr[0 +: 32]  = 32'h0000_0010;
    bus.req_wdata[0 +: 32] = 32'hDEAD_BEEF;
    bus.PREADY = 1'b1; bus.PRDATA = 32'hAAAA_5555;
    #1 check("wr_grant", bus.req_ready, 2'b01);
    tick(); bus.req_valid = '0;
    check("wr_setup_psel", bus.PSEL, 1'b1);
    check("wr_setup_pen",  bus.PENABLE, 1'b0);
    check("wr_paddr",      bus.PADDR, 32'h10);
    check("wr_pwdata",     bus.PWDATA, 32'hDEAD_BEEF);
    check("wr_pwrite",     bus.PWRITE, 1'b1);
    tick();
    check("wr_access_pen", bus.PENABLE, 1'b1);
    tick(); bus.PREADY = 1'b0;
    check("wr_rsp_valid", bus.rsp_valid, 2'b01);
    check("wr_rsp_err",   bus.rsp_err, 1'b0);
    check("wr_rsp_rdata", bus.rsp_rdata, 32'h0);

    // Read from req1 with 3 wait states.
    bus.req_valid = 2'b10; bus.req_write = 2'b00;
    bus.req_addr[32 +: 32] = 32'h0000_0020;
    #1 check("rd_grant", bus.req_ready, 2'b10);
    tick(); bus.req_valid = '0;
    check("rd_setup_paddr", bus.PADDR, 32'h20);
    for (int c = 2; c <= 5; c++) begin
      tick();
      if (c == 5) begin bus.PREADY = 1'b1; bus.PRDATA = 32'h1234_5678; end
      check("rd_access_pen", bus.PENABLE, 1'b1);
      check("rd_paddr_hold", bus.PADDR, 32'h20);
      check("rd_no_rsp",     bus.rsp_valid, 2'b00);
    end
    tick(); bus.PREADY = 1'b0;
    check("rd_rsp_valid", bus.rsp_valid, 2'b10);
    check("rd_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
    check("rd_psel_off",  bus.PSEL, 1'b0);

    // Both requesters continuously pending: grants alternate with no idle gap.
    bus.req_valid = 2'b11; bus.req_write = 2'b10;
    bus.req_addr  = {32'h0000_0104, 32'h0000_0100};
    bus.req_wdata = {32'h2222_2222, 32'h1111_1111};
    bus.PREADY = 1'b1; bus.PRDATA = 32'h0BAD_F00D;
    grant_log.delete();
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 7) bus.req_valid = '0;
      check("b2b_psel", bus.PSEL, 1'b1);
    end
    tick(); bus.PREADY = 1'b0;
    check("b2b_psel_off", bus.PSEL, 1'b0);
    check("b2b_ngrants", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("b2b_order", grant_log[i], i % 2);

    // PREADY stuck low: abort after TIMEOUT ACCESS cycles, then a normal transfer.
    bus.req_valid = 2'b01; bus.req_write = 2'b00;
    bus.req_addr[0 +: 32] = 32'h0000_0030;
    tick(); bus.req_valid = '0;
    for (int c = 2; c <= 1 + TIMEOUT; c++) begin
      tick();
      check("to_access_pen", bus.PENABLE, 1'b1);
      check("to_no_rsp",     bus.rsp_valid, 2'b00);
    end
    tick();
    check("to_rsp_valid", bus.rsp_valid, 2'b01);
    check("to_rsp_err",   bus.rsp_err, 1'b1);
    check("to_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("to_psel_off",  bus.PSEL, 1'b0);
    bus.req_valid = 2'b10; bus.req_write = 2'b10;
    bus.req_addr[32 +: 32] = 32'h0000_0040;
    bus.PREADY = 1'b1;
    #1 check("to_next_grant", bus.req_ready, 2'b10);
    tick(); bus.req_valid = '0;
    tick(); tick(); bus.PREADY = 1'b0;
    check("to_next_rsp", bus.rsp_valid, 2'b10);
    check("to_next_err", bus.rsp_err, 1'b0);

    // PREADY arrives on the last allowed ACCESS cycle: completion wins.
    bus.req_valid = 2'b01; bus.req_write = 2'b00;
    tick(); bus.req_valid = '0;
    for (int c = 2; c <= TIMEOUT; c++) tick();
    tick(); bus.PREADY = 1'b1; bus.PRDATA = 32'hCAFE_0001;
    tick(); bus.PREADY = 1'b0;
    check("edge_rsp_valid", bus.rsp_valid, 2'b01);
    check("edge_rsp_err",   bus.rsp_err, 1'b0);
    check("edge_rsp_rdata", bus.rsp_rdata, 32'hCAFE_0001);

    // Reset in the middle of ACCESS: no response, everything cleared, ptr back to 0.
    bus.req_valid = 2'b01; bus.req_write = 2'b00;
    tick(); bus.req_valid = '0;
    tick(); tick();
    check("mid_access_pen", bus.PENABLE, 1'b1);
    presetn = 1'b0; bus.req_valid = 2'b11;
    #1 check("mid_rst_ready", bus.req_ready, 2'b00);
    tick();
    check("mid_rst_psel",   bus.PSEL, 1'b0);
    check("mid_rst_pen",    bus.PENABLE, 1'b0);
    check("mid_rst_busy",   bus.busy, 1'b0);
    check("mid_rst_rsp",    bus.rsp_valid, 2'b00);
    check("mid_rst_paddr",  bus.PADDR, 32'h0);
    check("mid_rst_pwdata", bus.PWDATA, 32'h0);
    presetn = 1'b1;
    #1 check("post_rst_grant", bus.req_ready, 2'b01);
    bus.PREADY = 1'b1;
    tick(); bus.req_valid = '0;
    tick(); tick(); tick(); tick();
    bus.PREADY = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
